// File: rtl/pipelined_datapath.sv
// Three-stage register-file/ALU datapath with full forwarding. The result appears one cycle after acceptance.
// Every stage advances only when the output slot is empty or being consumed, and instr_ready mirrors that condition.
module pipelined_datapath #(
  parameter int DSIZE = 16,
  parameter int AW = 4,
  localparam int ISIZE = 4 + 3*AW
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [ISIZE-1:0] Instruction,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [DSIZE-1:0] DataInit,
  input  logic             InitSel,
  output logic [DSIZE-1:0] ALUOut,
  output logic [AW-1:0]    out_waddr,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int NREG = 2**AW;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_ADDI = 4'd7;

  typedef struct packed {
    logic             vld;
    logic             we;
    logic             init;
    logic [3:0]       op;
    logic [AW-1:0]    waddr;
    logic [AW-1:0]    imm;
    logic [DSIZE-1:0] a;
    logic [DSIZE-1:0] b;
  } ex_t;

  typedef struct packed {
    logic             vld;
    logic             we;
    logic [AW-1:0]    waddr;
    logic [DSIZE-1:0] res;
  } wb_t;

  logic [DSIZE-1:0] rf [NREG];
  ex_t              ex_q, ex_d;
  wb_t              wb_q, wb_d;
  logic             adv, accept;
  logic [3:0]       id_op;
  logic [AW-1:0]    id_waddr, id_raddr1, id_raddr2;
  logic [DSIZE-1:0] opa, opb, ex_res;
  logic [AW-1:0]    shamt;

  assign id_op     = Instruction[ISIZE-1 -: 4];
  assign id_waddr  = Instruction[3*AW-1 -: AW];
  assign id_raddr1 = Instruction[2*AW-1 -: AW];
  assign id_raddr2 = Instruction[AW-1:0];

  assign adv         = !out_valid || out_ready;
  assign instr_ready = adv;
  assign accept      = instr_valid && adv;

  // Later assignments override earlier ones, so EX beats WB beats the register file.
  // The we flags are only ever set on valid stages, so they double as stage-valid qualifiers.
  always_comb begin
    opa = rf[id_raddr1];
    opb = rf[id_raddr2];
    if (wb_q.we && wb_q.waddr == id_raddr1) opa = wb_q.res;
    if (wb_q.we && wb_q.waddr == id_raddr2) opb = wb_q.res;
    if (ex_q.we && ex_q.waddr == id_raddr1) opa = ex_res;
    if (ex_q.we && ex_q.waddr == id_raddr2) opb = ex_res;
  end

  always_comb begin
    ex_d = '0;
    if (accept) begin
      ex_d.vld   = 1'b1;
      ex_d.init  = !InitSel;
      ex_d.op    = id_op;
      ex_d.we    = !InitSel || !id_op[3];
      ex_d.waddr = id_waddr;
      ex_d.imm   = id_raddr2;
      ex_d.a     = InitSel ? opa : DataInit;
      ex_d.b     = opb;
    end
  end

  always_comb begin
    shamt  = AW'(32'(ex_q.imm) % DSIZE);
    ex_res = '0;
    if (ex_q.init) begin
      ex_res = ex_q.a;
    end else begin
      case (ex_q.op)
        OP_ADD:  ex_res = ex_q.a + ex_q.b;
        OP_SUB:  ex_res = ex_q.a - ex_q.b;
        OP_AND:  ex_res = ex_q.a & ex_q.b;
        OP_OR:   ex_res = ex_q.a | ex_q.b;
        OP_XOR:  ex_res = ex_q.a ^ ex_q.b;
        OP_SLL:  ex_res = ex_q.a << shamt;
        OP_SRL:  ex_res = ex_q.a >> shamt;
        OP_ADDI: ex_res = ex_q.a + DSIZE'(ex_q.imm);
        default: ex_res = '0;
      endcase
    end
  end

  always_comb begin
    wb_d       = '0;
    wb_d.vld   = ex_q.vld;
    wb_d.we    = ex_q.vld && ex_q.we;
    wb_d.waddr = ex_q.waddr;
    wb_d.res   = ex_q.vld ? ex_res : '0;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      ex_q <= '0;
      wb_q <= '0;
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else begin
      if (adv) begin
        ex_q <= ex_d;
        wb_q <= wb_d;
      end
      // Results retire into the register file only when the consumer takes them.
      if (out_valid && out_ready && wb_q.we) rf[wb_q.waddr] <= wb_q.res;
    end
  end

  assign out_valid = wb_q.vld;
  assign ALUOut    = wb_q.res;
  assign out_waddr = wb_q.waddr;

endmodule

// File: doc/pipelined_datapath.md
# pipelined_datapath

Parametrised three-stage (decode/read, execute, writeback) successor to the single-cycle register-file/ALU datapath. Accepts one instruction per cycle over a valid/ready handshake, forwards in-flight results so back-to-back dependent instructions never stall, and presents every result on a valid/ready output port. Register writes retire only when the result is consumed. It sits between the instruction source and the result consumer as the core execution path.

## Interface
- DSIZE, 16: data width in bits (≥ 4)
- AW, 4: register address width; register count NREG = 2**AW
- ISIZE, 4+3*AW: instruction width (derived, not overridden); fields [ISIZE-1 -: 4] opcode, next AW bits waddr, next AW bits raddr1, low AW bits raddr2/imm
- Clock  in  1  single clock, rising edge
- Reset  in  1  synchronous, active-high
- Instruction  in  ISIZE  instruction word
- instr_valid  in  1  Instruction/DataInit/InitSel valid
- instr_ready  out  1  datapath can accept this cycle
- DataInit  in  DSIZE  init value, used when InitSel=0
- InitSel  in  1  0: write DataInit to waddr; 1: execute opcode
- ALUOut  out  DSIZE  result of the oldest retiring instruction
- out_waddr  out  AW  destination register of ALUOut
- out_valid  out  1  ALUOut/out_waddr valid
- out_ready  in  1  consumer accepts result

## Operation
- Opcodes (InitSel=1): 0 ADD A+B; 1 SUB A−B; 2 AND; 3 OR; 4 XOR; 5 SLL A<<(imm mod DSIZE); 6 SRL A>>(imm mod DSIZE), logical; 7 ADDI A+zero-extended imm; 8–15 NOP (ALUOut=0, no register write). A=R[raddr1], B=R[raddr2], imm=raddr2 field.
- InitSel=0: opcode ignored; result=DataInit, written to waddr.
- All arithmetic wraps modulo 2**DSIZE; no flags.
- Advance signal adv = !out_valid | out_ready; every stage moves only on adv; instr_ready = adv (combinational from out_valid/out_ready).
- Accept: instr_valid & instr_ready at a rising edge. Operands are read at acceptance with forwarding priority: EX stage (combinational result) > WB stage (registered result) > register file. Forwarding applies only from valid, writing (non-NOP) stages.
- Retire: register file written at the edge where out_valid & out_ready; NOPs retire without write.
- Register file: NREG×DSIZE, one write port, two read ports; any address, including 0, is a normal register.
- Stall (out_valid & !out_ready): all stages hold, instr_ready=0, no write; forwarding still uses held values.
- Bubbles (no accept) travel as invalid stages; out_valid low when the WB stage is empty.

## Timing
- Reset: out_valid=0, ALUOut=0, out_waddr=0, all stage valids=0, all registers cleared to 0; instr_ready=1 the cycle after Reset deasserts. Reset mid-operation discards all in-flight instructions; no write happens on the reset edge.
- Latency: accepted at edge T → ALUOut/out_valid present after edge T+1 (unstalled); written to register file at the first edge ≥T+2 where out_ready=1.
- Throughput: one instruction per cycle with out_ready held high.
- Dependent instruction accepted the cycle after its producer receives EX-forwarded value; two cycles after, WB-forwarded; three or more, register file value (or WB if still stalled).
- Simultaneous retire-write and accept reading same register: new instruction sees retiring value (WB forward).
- Two in-flight writers to same register: younger (EX) wins.

## Test plan
- Reset, then init R1=0x0005, R2=0x0003 (InitSel=0), then ADD R3=R1+R2 → ALUOut 0x0005, 0x0003, 0x0008 on consecutive out_valid cycles; R3=0x0008.
- Back-to-back chain ADDI R4=R3+1, ADDI R4=R4+1, SUB R5=R4−R1, no gaps → ALUOut 0x0009, 0x000A, 0x0005; instr_ready never drops.
- Wrap/shift: R6=0xFFFF, ADDI R7=R6+2 → 0x0001; SLL R8=R6<<4 → 0xFFF0; SRL R9=R6>>15 → 0x0001.
- Backpressure: out_ready low 3 cycles mid-stream → instr_ready low same cycles, ALUOut stable, no register change; stream resumes with no lost or duplicated results.
- NOP opcode 0xF with waddr=R1 → out_valid with ALUOut=0x0000, R1 unchanged (still 0x0005).
- Reset asserted with two instructions in flight → out_valid=0 next cycle, no register written, all registers read 0x0000.
